// File: rtl/puzzle_ctrl.sv
// puzzle_ctrl: fetch/decode/execute controller for the 15-puzzle ALU; define CTRL_SINGLE_STEP_EN for step/STALL mode
module puzzle_ctrl #(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [4:0]      alu_op,
  output logic [4:0]      alu_ina,
  output logic [4:0]      alu_inb,
  input  logic [4:0]      alu_out,
  input  logic            alu_zf,
  output logic            busy,
  output logic            done,
  output logic            zf_q,
  input  logic [2:0]      dbg_sel,
  output logic [4:0]      dbg_data
);
  localparam logic [4:0] OP_INC     = 5'd1;
  localparam logic [4:0] OP_DEC     = 5'd2;
  localparam logic [4:0] OP_LI      = 5'd3;
  localparam logic [4:0] OP_COPY    = 5'd4;
  localparam logic [4:0] OP_RL      = 5'd5;
  localparam logic [4:0] OP_CARD    = 5'd6;
  localparam logic [4:0] OP_RCOPI1  = 5'd7;
  localparam logic [4:0] OP_RCOPD1  = 5'd8;
  localparam logic [4:0] OP_RCOPI3  = 5'd9;
  localparam logic [4:0] OP_RCOPD3  = 5'd10;
  localparam logic [4:0] OP_RLI1    = 5'd11;
  localparam logic [4:0] OP_RLD1    = 5'd12;
  localparam logic [4:0] OP_RLI3    = 5'd13;
  localparam logic [4:0] OP_RLD3    = 5'd14;
  localparam logic [4:0] OP_REDST30 = 5'd15;
  localparam logic [4:0] OP_COMP    = 5'd16;
  localparam logic [4:0] OP_CHECK   = 5'd17;
  localparam logic [4:0] OP_LESS    = 5'd18;
  localparam logic [4:0] OP_MORE    = 5'd19;
  localparam logic [4:0] OP_AMARIN0 = 5'd20;
  localparam logic [4:0] OP_AMARI1  = 5'd21;
  localparam logic [4:0] OP_CHECK30 = 5'd22;
  localparam logic [4:0] OP_BRZ     = 5'd29;
  localparam logic [4:0] OP_JMP     = 5'd30;
  localparam logic [4:0] OP_HALT    = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_STALL
  } state_t;

  // Where the FSM goes once an instruction has retired (WB or resolved branch).
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t S_NEXT = S_STALL;
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt;
  logic [15:0]     instr_q;
  logic [4:0]      aop_q, ina_q, inb_q, res_q;
  logic            rzf_q;
  logic [4:0]      rf_q [NREG];
  logic [4:0]      op, imm, ina_d;
  logic [2:0]      rd, rs;
  logic            is_wr, is_flag;

  // Field extraction and op classification of the latched instruction.
  always_comb begin
    op      = instr_q[15:11];
    rd      = instr_q[10:8];
    rs      = instr_q[7:5];
    imm     = instr_q[4:0];
    tgt     = PC_W'(instr_q[7:0]);
    pc_inc  = pc_q + PC_W'(1);
    is_wr   = op inside {OP_INC, OP_DEC, OP_LI, OP_COPY, OP_RL, OP_CARD,
                         OP_RCOPI1, OP_RCOPD1, OP_RCOPI3, OP_RCOPD3,
                         OP_RLI1, OP_RLD1, OP_RLI3, OP_RLD3, OP_REDST30};
    is_flag = op inside {OP_COMP, OP_CHECK, OP_LESS, OP_MORE,
                         OP_AMARIN0, OP_AMARI1, OP_CHECK30};
    ina_d   = op == OP_LI ? imm : (op == OP_INC || op == OP_DEC) ? rf_q[rd] : rf_q[rs];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; branches and HALT bypass EXEC/WB.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = op == OP_HALT ? S_HALT :
                          (op == OP_JMP || op == OP_BRZ) ? S_NEXT : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_NEXT;
      S_HALT:   if (start) state_d = S_FETCH;
`ifdef CTRL_SINGLE_STEP_EN
      S_STALL:  if (step) state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    imem_req  = state_q == S_FETCH;
    imem_addr = pc_q;
    busy      = !(state_q == S_IDLE || state_q == S_HALT);
    done      = state_q == S_HALT;
    alu_op    = aop_q;
    alu_ina   = ina_q;
    alu_inb   = inb_q;
    dbg_data  = rf_q[dbg_sel];
  end

  // Program counter update: restart, branch resolve in DECODE, increment in WB (wraps freely).
  always_comb begin
    pc_d = pc_q;
    if ((state_q == S_IDLE || state_q == S_HALT) && start) pc_d = '0;
    if (state_q == S_DECODE && op == OP_JMP) pc_d = tgt;
    if (state_q == S_DECODE && op == OP_BRZ) pc_d = zf_q ? tgt : pc_inc;
    if (state_q == S_WB) pc_d = pc_inc;
  end

  // Datapath registers: instruction latch, ALU drive, result hold, writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      aop_q   <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      res_q   <= '0;
      rzf_q   <= 1'b0;
      zf_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && imem_ack) instr_q <= imem_data;
      if (state_q == S_DECODE) begin
        aop_q <= (is_wr || is_flag) ? op : '0;
        ina_q <= ina_d;
        inb_q <= rf_q[rd];
      end
      if (state_q == S_EXEC) begin
        res_q <= alu_out;
        rzf_q <= alu_zf;
      end
      if (state_q == S_WB && is_wr) rf_q[rd] <= res_q;
      if (state_q == S_WB && is_flag) zf_q <= rzf_q;
    end
  end
endmodule

// File: tb/tb_puzzle_ctrl.sv
// tb_puzzle_ctrl: scoreboard bench for puzzle_ctrl with an instruction memory and ALU model
module tb_puzzle_ctrl;
  localparam logic [4:0] INC = 5'd1, LI = 5'd3, COMP = 5'd16;
  localparam logic [4:0] BRZ = 5'd29, JMP = 5'd30, HALT = 5'd31, UNDEF = 5'd25;

  logic        clk = 0, rst_n = 0, start = 0, imem_ack = 0;
  logic        imem_req, alu_zf, busy, done, zf_q;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 0;
  logic [4:0]  alu_op, alu_ina, alu_inb, alu_out, dbg_data;
  logic [2:0]  dbg_sel = 0;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step = 1;
`endif

  typedef struct {logic [4:0] op, a, b; bit m;} alu_t;
  alu_t        aq[$];
  logic [7:0]  fq[$];
  alu_t        e;
  logic [15:0] mem [256];
  int          checks = 0, errors = 0, pend = 0, ack_delay = 0, wait_cnt = 0;

  puzzle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_out(alu_out), .alu_zf(alu_zf),
    .busy(busy), .done(done), .zf_q(zf_q), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = alu_op == INC ? alu_ina + 5'd1 : alu_ina;
    alu_zf  = alu_ina == alu_inb;
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [15:0] br(input logic [4:0] op, input logic [7:0] t);
    return {op, 3'd0, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_alu(input logic [4:0] op, input logic [4:0] a, input logic [4:0] b, input bit m);
    alu_t t;
    t.op = op; t.a = a; t.b = b; t.m = m;
    aq.push_back(t);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reg(input int r, input logic [4:0] v);
    dbg_sel = r[2:0];
    #1 check($sformatf("reg%0d", r), dbg_data, v);
  endtask

  // Instruction memory: answers a request after ack_delay waiting cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      imem_ack = 0;
      if (imem_req) begin
        if (wait_cnt < ack_delay) wait_cnt++;
        else begin
          imem_ack = 1;
          imem_data = mem[imem_addr];
          wait_cnt = 0;
        end
      end else wait_cnt = 0;
    end
  end

  // Monitor: accepted fetches and the ALU drive two cycles later are popped against the queues.
  always @(negedge clk) begin
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (aq.size() == 0) begin
          checks++; errors++;
          $display("FAIL alu_unexpected: got op %0h expected none", alu_op);
        end else begin
          e = aq.pop_front();
          check("alu_op", alu_op, e.op);
          if (!e.m) begin
            check("alu_ina", alu_ina, e.a);
            check("alu_inb", alu_inb, e.b);
          end
        end
      end
    end
    if (rst_n && imem_req && imem_ack) begin
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_unexpected: got addr %0h expected none", imem_addr);
      end else check("fetch_addr", imem_addr, fq.pop_front());
      pend = 2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = br(HALT, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_zf", zf_q, 0);
    check("rst_aluop", alu_op, 0);
    rst_n = 1;

    // LI r1,7; INC r1; HALT
    mem[0] = ins(LI, 1, 0, 7); mem[1] = ins(INC, 1, 0, 0); mem[2] = br(HALT, 0);
    fq.push_back(0); fq.push_back(1); fq.push_back(2);
    exp_alu(LI, 7, 0, 0); exp_alu(INC, 7, 7, 0); exp_alu(0, 0, 0, 1);
    pulse_start();
    wait_done();
    chk_reg(1, 8);

    // LI r2,5; LI r3,5; COMP r3,r2; BRZ 0x10 (taken)
    mem[0] = ins(LI, 2, 0, 5); mem[1] = ins(LI, 3, 0, 5);
    mem[2] = ins(COMP, 3, 2, 0); mem[3] = br(BRZ, 8'h10);
    fq.push_back(0); fq.push_back(1); fq.push_back(2); fq.push_back(3); fq.push_back(8'h10);
    exp_alu(LI, 5, 0, 0); exp_alu(LI, 5, 0, 0); exp_alu(COMP, 5, 5, 0);
    exp_alu(0, 0, 0, 1); exp_alu(0, 0, 0, 1);
    pulse_start();
    wait_done();
    check("zf_taken", zf_q, 1);

    // Same with r3=4: branch not taken
    mem[1] = ins(LI, 3, 0, 4);
    fq.push_back(0); fq.push_back(1); fq.push_back(2); fq.push_back(3); fq.push_back(4);
    exp_alu(LI, 5, 5, 0); exp_alu(LI, 4, 5, 0); exp_alu(COMP, 5, 4, 0);
    exp_alu(0, 0, 0, 1); exp_alu(0, 0, 0, 1);
    pulse_start();
    wait_done();
    check("zf_not_taken", zf_q, 0);

    // Slow memory; INC r1; undefined op; HALT
    ack_delay = 5;
    mem[0] = ins(INC, 1, 0, 0); mem[1] = ins(UNDEF, 1, 1, 0); mem[2] = br(HALT, 0);
    fq.push_back(0); fq.push_back(1); fq.push_back(2);
    exp_alu(INC, 8, 8, 0); exp_alu(0, 0, 0, 1); exp_alu(0, 0, 0, 1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 0);
    end
    wait_done();
    ack_delay = 0;
    chk_reg(1, 9);
    check("zf_kept_undef", zf_q, 0);

    // JMP 0xFF; INC r1 at 0xFF wraps to 0
    mem[0] = br(JMP, 8'hFF); mem[8'hFF] = ins(INC, 1, 0, 0);
    fq.push_back(0); fq.push_back(8'hFF); fq.push_back(0);
    exp_alu(0, 0, 0, 1); exp_alu(INC, 9, 9, 0); exp_alu(0, 0, 0, 1);
    pulse_start();
    for (int i = 0; i < 50 && !(imem_req && imem_addr == 8'hFF); i++) @(negedge clk);
    check("reach_ff", imem_req && imem_addr == 8'hFF, 1);
    mem[0] = br(HALT, 0);
    wait_done();
    chk_reg(1, 10);

`ifdef CTRL_SINGLE_STEP_EN
    // Single step: LI r1,3 parks in STALL until step
    step = 0;
    mem[0] = ins(LI, 1, 0, 3); mem[1] = br(HALT, 0);
    fq.push_back(0); fq.push_back(1);
    exp_alu(LI, 3, 10, 0); exp_alu(0, 0, 0, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_req", imem_req, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1 step = 1;
    @(posedge clk); #1 step = 0;
    @(negedge clk);
    check("step_req", imem_req, 1);
    check("step_addr", imem_addr, 1);
    step = 1;
    wait_done();
    chk_reg(1, 3);
`endif

    // Reset during a stalled fetch
    ack_delay = 20;
    mem[0] = ins(INC, 1, 0, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    check("req_before_rst", imem_req, 1);
    rst_n = 0;
    #1;
    check("rst_mid_req", imem_req, 0);
    check("rst_mid_addr", imem_addr, 0);
    check("rst_mid_busy", busy, 0);
    for (int s = 0; s < 8; s++) chk_reg(s, 0);
    @(negedge clk);
    rst_n = 1;
    ack_delay = 0;
    repeat (3) @(negedge clk);
    check("fetch_q_empty", fq.size(), 0);
    check("alu_q_empty", aq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
